// File: rtl/lock_pkg.sv
// Shared types and constants for the canal lock chamber controller:
// FSM state encoding, level type and switch/request bit positions.
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    OUTER_OPEN,
    INNER_OPEN,
    FILL,
    DRAIN
  } lock_state_t;

  localparam int LVL_W_DEF = 7;
  typedef logic [LVL_W_DEF-1:0] level_t;

  // Door/pump requests occupy the low bits so they can be sliced as a group
  localparam int REQ_OUTER = 0;
  localparam int REQ_INNER = 1;
  localparam int REQ_FILL  = 2;
  localparam int REQ_DRAIN = 3;
  localparam int N_REQ     = 4;
  localparam int SW_ARR    = 4;
  localparam int SW_DEPT   = 5;
  localparam int N_SW      = 6;

  function automatic logic multi_req(input logic [N_REQ-1:0] r);
    return (r & (r - 1'b1)) != '0;
  endfunction

endpackage

// File: rtl/lock_chamber_ctrl_if.sv
// Board-side bundle of chamber switches and indicator outputs.
// master = switch/LED board, slave = chamber controller.
interface lock_chamber_ctrl_if #(
  parameter int LVL_W = 7
);
  logic             arr_sw;
  logic             dept_sw;
  logic             toggle_outer_sw;
  logic             toggle_inner_sw;
  logic             fill_sw;
  logic             drain_sw;
  logic             arr_led;
  logic             dept_led;
  logic             toggle_outer_led;
  logic             toggle_inner_led;
  logic             filling;
  logic             draining;
  logic [LVL_W-1:0] water_level;
  logic             reject;

  modport master (
    output arr_sw, dept_sw, toggle_outer_sw, toggle_inner_sw, fill_sw, drain_sw,
    input  arr_led, dept_led, toggle_outer_led, toggle_inner_led,
           filling, draining, water_level, reject
  );

  modport slave (
    input  arr_sw, dept_sw, toggle_outer_sw, toggle_inner_sw, fill_sw, drain_sw,
    output arr_led, dept_led, toggle_outer_led, toggle_inner_led,
           filling, draining, water_level, reject
  );
endinterface

// File: rtl/lock_rate_timer.sv
// Free-running pump-tick prescaler plus a rate counter that emits one step
// pulse every `div` ticks; clr zeroes and holds the rate counter.
module lock_rate_timer #(
  parameter int TICK_DIV = 50_000_000,
  parameter int RATE_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic [RATE_W-1:0] div,
  output logic              step
);
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic              tick;

  always_comb begin
    tick   = (pre_q == PRE_LAST);
    pre_d  = tick ? '0 : pre_q + 1'b1;
    rate_d = rate_q;
    step   = 1'b0;
    if (clr) begin
      rate_d = '0;
    end else if (tick) begin
      if (rate_q >= div - 1'b1) begin
        rate_d = '0;
        step   = 1'b1;
      end else begin
        rate_d = rate_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_q  <= '0;
      rate_q <= '0;
    end else begin
      pre_q  <= pre_d;
      rate_q <= rate_d;
    end
  end

endmodule

// File: rtl/lock_chamber_ctrl.sv
// Lock chamber controller: door interlocks, fill/drain pumping, notice LEDs.
// Optional AUTO_EQUALISE_EN: mismatched door toggle pumps toward that side.
//
// state      | meaning
// IDLE       | doors shut, pumps off
// OUTER_OPEN | outer door open
// INNER_OPEN | inner door open
// FILL       | fill pump running, level rising
// DRAIN      | drain pump running, level falling
module lock_chamber_ctrl
  import lock_pkg::*;
#(
  parameter int LVL_W       = LVL_W_DEF,
  parameter int OUTER_LVL   = 40,
  parameter int INNER_LVL   = 60,
  parameter int TOL         = 3,
  parameter int TICK_DIV    = 50_000_000,
  parameter int FILL_TICKS  = 8,
  parameter int DRAIN_TICKS = 7
) (
  input logic               clk,
  input logic               reset,
  lock_chamber_ctrl_if.slave bus
);
  localparam logic [LVL_W-1:0]    OUTER_L  = LVL_W'(OUTER_LVL);
  localparam logic [LVL_W-1:0]    INNER_L  = LVL_W'(INNER_LVL);
  localparam logic signed [LVL_W:0] TOL_S  = (LVL_W+1)'(TOL);
  localparam int RATE_MAX = (FILL_TICKS > DRAIN_TICKS) ? FILL_TICKS : DRAIN_TICKS;
  localparam int RATE_W   = $clog2(RATE_MAX + 1);

  logic [N_SW-1:0]  sw_raw, sw1_q, sw1_d, sw2_q, sw2_d, sw_edge;
  logic [N_REQ-1:0] req;
  lock_state_t      state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic arr_q, arr_d, dept_q, dept_d;
  logic door_out_q, door_out_d, door_in_q, door_in_d;
  logic fill_q, fill_d, drain_q, drain_d;
  logic reject_q, reject_d;
  logic step, pump_clr;
  logic [RATE_W-1:0] rate_div;
`ifdef AUTO_EQUALISE_EN
  logic eq_out_q, eq_out_d, eq_in_q, eq_in_d;
`endif

  function automatic logic near(input logic [LVL_W-1:0] lvl, input logic [LVL_W-1:0] tgt);
    logic signed [LVL_W:0] diff;
    diff = $signed({1'b0, lvl}) - $signed({1'b0, tgt});
    return (diff <= TOL_S) && (diff >= -TOL_S);
  endfunction

  assign sw_raw = {bus.dept_sw, bus.arr_sw, bus.drain_sw, bus.fill_sw,
                   bus.toggle_inner_sw, bus.toggle_outer_sw};

  // Rate counter only advances while pumping, so every pump start begins fresh
  assign pump_clr = !(state_q == FILL || state_q == DRAIN);
  assign rate_div = (state_q == FILL) ? RATE_W'(FILL_TICKS) : RATE_W'(DRAIN_TICKS);

  lock_rate_timer #(
    .TICK_DIV (TICK_DIV),
    .RATE_W   (RATE_W)
  ) u_rate_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (pump_clr),
    .div   (rate_div),
    .step  (step)
  );

  always_comb begin
    sw1_d    = sw_raw;
    sw2_d    = sw1_q;
    sw_edge  = sw1_q & ~sw2_q;
    req      = sw_edge[N_REQ-1:0];
    state_d  = state_q;
    level_d  = level_q;
    reject_d = 1'b0;
    arr_d    = arr_q;
    dept_d   = dept_q;
`ifdef AUTO_EQUALISE_EN
    eq_out_d = eq_out_q;
    eq_in_d  = eq_in_q;
`endif
    if (multi_req(req)) begin
      reject_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (req[REQ_OUTER]) begin
            if (near(level_q, OUTER_L)) state_d = OUTER_OPEN;
            else begin
`ifdef AUTO_EQUALISE_EN
              eq_out_d = 1'b1;
              state_d  = (level_q > OUTER_L) ? DRAIN : FILL;
`else
              reject_d = 1'b1;
`endif
            end
          end else if (req[REQ_INNER]) begin
            if (near(level_q, INNER_L)) state_d = INNER_OPEN;
            else begin
`ifdef AUTO_EQUALISE_EN
              eq_in_d = 1'b1;
              state_d = (level_q > INNER_L) ? DRAIN : FILL;
`else
              reject_d = 1'b1;
`endif
            end
          end else if (req[REQ_FILL]) begin
            if (level_q < INNER_L) state_d = FILL;
            else reject_d = 1'b1;
          end else if (req[REQ_DRAIN]) begin
            if (level_q > OUTER_L) state_d = DRAIN;
            else reject_d = 1'b1;
          end
        end
        OUTER_OPEN: begin
          if (req[REQ_OUTER]) state_d = IDLE;
          else if (|req) reject_d = 1'b1;
        end
        INNER_OPEN: begin
          if (req[REQ_INNER]) state_d = IDLE;
          else if (|req) reject_d = 1'b1;
        end
        FILL: begin
          if (|req) begin
`ifdef AUTO_EQUALISE_EN
            if (eq_out_q || eq_in_q) begin
              state_d  = IDLE;
              reject_d = 1'b1;
            end else
`endif
            if (req[REQ_FILL]) state_d = IDLE;
            else reject_d = 1'b1;
          end else if (step) begin
            level_d = level_q + 1'b1;
            if (level_d == INNER_L) state_d = IDLE;
`ifdef AUTO_EQUALISE_EN
            if (eq_out_q && near(level_d, OUTER_L)) state_d = OUTER_OPEN;
            if (eq_in_q && near(level_d, INNER_L)) state_d = INNER_OPEN;
`endif
          end
        end
        DRAIN: begin
          if (|req) begin
`ifdef AUTO_EQUALISE_EN
            if (eq_out_q || eq_in_q) begin
              state_d  = IDLE;
              reject_d = 1'b1;
            end else
`endif
            if (req[REQ_DRAIN]) state_d = IDLE;
            else reject_d = 1'b1;
          end else if (step) begin
            level_d = level_q - 1'b1;
            if (level_d == OUTER_L) state_d = IDLE;
`ifdef AUTO_EQUALISE_EN
            if (eq_out_q && near(level_d, OUTER_L)) state_d = OUTER_OPEN;
            if (eq_in_q && near(level_d, INNER_L)) state_d = INNER_OPEN;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef AUTO_EQUALISE_EN
    if (state_d != FILL && state_d != DRAIN) begin
      eq_out_d = 1'b0;
      eq_in_d  = 1'b0;
    end
`endif
    // Notice clear on door entry, but a same-cycle notice edge wins
    if (state_d == OUTER_OPEN && state_q != OUTER_OPEN) arr_d = 1'b0;
    if (state_d == INNER_OPEN && state_q != INNER_OPEN) dept_d = 1'b0;
    if (sw_edge[SW_ARR])  arr_d  = 1'b1;
    if (sw_edge[SW_DEPT]) dept_d = 1'b1;
    door_out_d = (state_d == OUTER_OPEN);
    door_in_d  = (state_d == INNER_OPEN);
    fill_d     = (state_d == FILL);
    drain_d    = (state_d == DRAIN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sw1_q      <= '0;
      sw2_q      <= '0;
      state_q    <= IDLE;
      level_q    <= OUTER_L;
      arr_q      <= 1'b0;
      dept_q     <= 1'b0;
      door_out_q <= 1'b0;
      door_in_q  <= 1'b0;
      fill_q     <= 1'b0;
      drain_q    <= 1'b0;
      reject_q   <= 1'b0;
`ifdef AUTO_EQUALISE_EN
      eq_out_q   <= 1'b0;
      eq_in_q    <= 1'b0;
`endif
    end else begin
      sw1_q      <= sw1_d;
      sw2_q      <= sw2_d;
      state_q    <= state_d;
      level_q    <= level_d;
      arr_q      <= arr_d;
      dept_q     <= dept_d;
      door_out_q <= door_out_d;
      door_in_q  <= door_in_d;
      fill_q     <= fill_d;
      drain_q    <= drain_d;
      reject_q   <= reject_d;
`ifdef AUTO_EQUALISE_EN
      eq_out_q   <= eq_out_d;
      eq_in_q    <= eq_in_d;
`endif
    end
  end

  assign bus.arr_led          = arr_q;
  assign bus.dept_led         = dept_q;
  assign bus.toggle_outer_led = door_out_q;
  assign bus.toggle_inner_led = door_in_q;
  assign bus.filling          = fill_q;
  assign bus.draining         = drain_q;
  assign bus.water_level      = level_q;
  assign bus.reject           = reject_q;

endmodule

// File: tb/tb_lock_chamber_ctrl.sv
// Directed bench for lock_chamber_ctrl with a fast pump tick (TICK_DIV=2).
// Covers AUTO_EQUALISE_EN builds where behaviour differs.
module tb_lock_chamber_ctrl;
  import lock_pkg::*;

  localparam logic [5:0] M_OUTER = 6'b000001;
  localparam logic [5:0] M_INNER = 6'b000010;
  localparam logic [5:0] M_FILL  = 6'b000100;
  localparam logic [5:0] M_DRAIN = 6'b001000;
  localparam logic [5:0] M_ARR   = 6'b010000;
  localparam logic [5:0] M_DEPT  = 6'b100000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   n;

  lock_chamber_ctrl_if #(.LVL_W(7)) bus ();

  lock_chamber_ctrl #(
    .LVL_W(7), .OUTER_LVL(40), .INNER_LVL(60), .TOL(3),
    .TICK_DIV(2), .FILL_TICKS(8), .DRAIN_TICKS(7)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [5:0] m);
    bus.toggle_outer_sw = m[0];
    bus.toggle_inner_sw = m[1];
    bus.fill_sw         = m[2];
    bus.drain_sw        = m[3];
    bus.arr_sw          = m[4];
    bus.dept_sw         = m[5];
  endtask

  // One-cycle switch pulse; returns just after the edge where the request lands
  task automatic press(input logic [5:0] m);
    @(negedge clk);
    drive(m);
    @(negedge clk);
    drive('0);
    @(posedge clk);
    #1;
  endtask

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_win(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic wait_level(input string tag, input level_t target, input int budget, output int cyc);
    cyc = 0;
    while (cyc < budget && bus.water_level !== target) begin
      step_cycle();
      cyc++;
    end
    chk(tag, 32'(bus.water_level), 32'(target));
  endtask

  function automatic logic [6:0] outs();
    return {bus.arr_led, bus.dept_led, bus.toggle_outer_led, bus.toggle_inner_led,
            bus.filling, bus.draining, bus.reject};
  endfunction

  initial begin
    drive('0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step_cycle();
    chk("reset_level", 32'(bus.water_level), 40);
    chk("reset_outs", 32'(outs()), 0);

    // Doors and notices at the outer level
    press(M_ARR);
    chk("arr_set", 32'(bus.arr_led), 1);
    press(M_OUTER);
    chk("outer_open", 32'(bus.toggle_outer_led), 1);
    chk("outer_open_level", 32'(bus.water_level), 40);
    chk("arr_clr_on_outer", 32'(bus.arr_led), 0);
    press(M_INNER);
    chk("outer_open_inner_rej", 32'(bus.reject), 1);
    chk("outer_open_inner_led", 32'(bus.toggle_inner_led), 0);
    chk("outer_stays_open", 32'(bus.toggle_outer_led), 1);
    step_cycle();
    chk("reject_one_cycle", 32'(bus.reject), 0);
    press(M_FILL);
    chk("outer_open_fill_rej", 32'(bus.reject), 1);
    chk("outer_open_no_fill", 32'(bus.filling), 0);
    press(M_OUTER);
    chk("outer_close", 32'(bus.toggle_outer_led), 0);
    press(M_DRAIN);
    chk("drain_at_outer_rej", 32'(bus.reject), 1);
    chk("drain_at_outer_off", 32'(bus.draining), 0);
`ifndef AUTO_EQUALISE_EN
    press(M_INNER);
    chk("inner_at_40_rej", 32'(bus.reject), 1);
    chk("inner_at_40_closed", 32'(bus.toggle_inner_led), 0);
`endif
    press(M_DEPT);
    chk("dept_set", 32'(bus.dept_led), 1);

    // Fill timing: first step 15..16 cycles, then exactly 16 per unit
    press(M_FILL);
    chk("fill_start", 32'(bus.filling), 1);
    wait_level("fill_to_41", 41, 40, n);
    chk_win("fill_first_step_cycles", n, 15, 16);
    wait_level("fill_to_42", 42, 40, n);
    chk("fill_step_interval", n, 16);
    wait_level("fill_to_43", 43, 40, n);
    press(M_FILL);
    chk("manual_stop", 32'(bus.filling), 0);
    chk("manual_stop_level", 32'(bus.water_level), 43);
    press(M_OUTER);
    chk("outer_open_at_tol", 32'(bus.toggle_outer_led), 1);
    press(M_OUTER);

    press(M_FILL);
    wait_level("fill_to_45", 45, 40, n);
    press(M_FILL);
    press(M_FILL | M_DRAIN);
    chk("dual_req_reject", 32'(bus.reject), 1);
    chk("dual_req_no_pump", 32'({bus.filling, bus.draining}), 0);
    step_cycle();
    chk("dual_req_single_pulse", 32'(bus.reject), 0);
    repeat (20) step_cycle();
    chk("dual_req_level_hold", 32'(bus.water_level), 45);

    // Requests refused while filling
    press(M_FILL);
    press(M_DRAIN);
    chk("fill_drain_rej", 32'(bus.reject), 1);
    chk("fill_keeps_running", 32'(bus.filling), 1);
    chk("fill_not_draining", 32'(bus.draining), 0);
    press(M_OUTER);
    chk("fill_outer_rej", 32'(bus.reject), 1);
    chk("fill_outer_closed", 32'(bus.toggle_outer_led), 0);
    wait_level("fill_to_50", 50, 120, n);
    press(M_FILL);
    chk("stop_at_50", 32'(bus.water_level), 50);

    press(M_INNER);
`ifdef AUTO_EQUALISE_EN
    chk("auto_no_reject", 32'(bus.reject), 0);
    chk("auto_filling", 32'(bus.filling), 1);
    wait_level("auto_to_57", 57, 140, n);
    chk("auto_inner_open", 32'(bus.toggle_inner_led), 1);
    chk("auto_pump_off", 32'(bus.filling), 0);
    chk("auto_dept_clr", 32'(bus.dept_led), 0);
    press(M_INNER);
`else
    chk("inner_mismatch_rej", 32'(bus.reject), 1);
    chk("inner_mismatch_closed", 32'(bus.toggle_inner_led), 0);
    press(M_FILL);
    wait_level("fill_to_54", 54, 80, n);
    press(M_FILL);
`endif

    // Drain timing and reset mid-drain
    press(M_DRAIN);
    chk("drain_start", 32'(bus.draining), 1);
    wait_level("drain_to_53", 53, 80, n);
    wait_level("drain_to_52", 52, 40, n);
    chk("drain_step_interval", n, 14);
    chk("draining_at_52", 32'(bus.draining), 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midrun_reset_level", 32'(bus.water_level), 40);
    chk("midrun_reset_outs", 32'(outs()), 0);
    repeat (30) step_cycle();
    chk("no_residual_pump", 32'({bus.filling, bus.draining}), 0);
    chk("no_residual_level", 32'(bus.water_level), 40);

    // Full fill with auto stop at the inner level
    press(M_FILL);
    n = 0;
    while (n < 400 && bus.filling === 1'b1) begin
      step_cycle();
      n++;
    end
    chk_win("full_fill_cycles", n, 319, 320);
    chk("full_fill_level", 32'(bus.water_level), 60);
    press(M_FILL);
    chk("fill_at_inner_rej", 32'(bus.reject), 1);
    chk("fill_at_inner_off", 32'(bus.filling), 0);
    press(M_DEPT);
    press(M_INNER);
    chk("inner_open", 32'(bus.toggle_inner_led), 1);
    chk("dept_clr_on_inner", 32'(bus.dept_led), 0);
    press(M_OUTER);
    chk("inner_open_outer_rej", 32'(bus.reject), 1);
    chk("inner_open_outer_closed", 32'(bus.toggle_outer_led), 0);
    press(M_FILL);
    chk("inner_open_fill_rej", 32'(bus.reject), 1);
    chk("inner_open_no_fill", 32'(bus.filling), 0);
    press(M_INNER);
    chk("inner_close", 32'(bus.toggle_inner_led), 0);
    press(M_INNER | M_DEPT);
    chk("set_wins_inner", 32'(bus.toggle_inner_led), 1);
    chk("set_wins_dept", 32'(bus.dept_led), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
